dffmem_bank: RTL and testbench

Parametrised successor to the fixed 8-word × 16-bit DFF memory: a flip-flop register-file bank with configurable width and depth, per-byte write enables, a registered read port with a valid strobe, write-first bypass, and a hardware clear sequencer. It sits behind the Tiny Tapeout pin wrapper. The wrapper maps `ui_in`/`uio_in` onto the write data and control lines, and maps `uo_out`/`uio_out` onto `rdata`.

---
 rtl/dffmem_bank.sv | 119 +++++++++++
 tb/tb_dffmem_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dffmem_bank.sv
// dffmem_bank: flip-flop register-file bank with byte enables, a registered
// write-first read port and a clear sequencer. Optional per-byte even parity
// is enabled by defining DFFMEM_PARITY_EN.
module dffmem_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic                  clr_req,
    input  logic                  perr_inj,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic                  perr
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;
    logic                         rvalid_q, rvalid_d;
    logic                         perr_q, perr_d;
    logic                         acc;

    // A clear request sampled in IDLE takes priority over the access ports.
    assign acc = (state_q == IDLE) && !clr_req;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) state_d = CLEAR;
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (acc && we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        // Reading from mem_d gives write-first bypass on address collision.
        if (acc && re) begin
            rdata_d  = mem_d[raddr];
            rvalid_d = 1'b1;
        end
    end

`ifdef DFFMEM_PARITY_EN
    logic [DEPTH-1:0][NB-1:0] par_q, par_d;
    logic [NB-1:0]            rd_bad;

    always_comb begin
        par_d  = par_q;
        rd_bad = '0;
        if (state_q == CLEAR) par_d[cnt_q] = '0;
        if (acc && we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) par_d[waddr][i] = (^wdata[8*i +: 8]) ^ perr_inj;
            end
        end
        for (int i = 0; i < NB; i++) begin
            rd_bad[i] = ^{par_d[raddr][i], mem_d[raddr][8*i +: 8]};
        end
        perr_d = acc && re && (|rd_bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= '0;
        else     par_q <= par_d;
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj;
    assign perr_d          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            perr_q   <= perr_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = (state_q == CLEAR);
    assign perr   = perr_q;
endmodule

// File: tb/tb_dffmem_bank.sv
// Self-checking bench for dffmem_bank: directed vector table, hand-written
// clear/reset sequences and randomized traffic against a behavioural model.
module tb_dffmem_bank;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0, re = 1'b0, clr_req = 1'b0, perr_inj = 1'b0;
    logic [1:0]    be = '0;
    logic [AW-1:0] waddr = '0, raddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          rvalid, busy, perr;

    dffmem_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .clr_req(clr_req), .perr_inj(perr_inj),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .perr(perr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: word contents, per-byte "parity corrupted" flags,
    // remaining busy cycles and the expected registered outputs.
    logic [DW-1:0] m_mem [DEPTH];
    logic [1:0]    m_bad [DEPTH];
    int            m_busy;
    logic [DW-1:0] e_rdata;
    logic          e_rvalid, e_perr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = '0;
        end
        m_busy   = 0;
        e_rdata  = '0;
        e_rvalid = 1'b0;
        e_perr   = 1'b0;
    endtask

    task automatic do_cycle(input logic w, input logic [1:0] b, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra,
                            input logic c, input logic inj);
        we = w; be = b; waddr = wa; wdata = wd; re = r; raddr = ra; clr_req = c; perr_inj = inj;
        @(posedge clk);
        #1;
        e_rvalid = 1'b0;
        e_perr   = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
        end else if (c) begin
            // Nothing is observable mid-clear, so the model clears everything at once.
            m_busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_bad[i] = '0;
            end
        end else begin
            if (w) begin
                for (int i = 0; i < 2; i++) begin
                    if (b[i]) begin
                        m_mem[wa][8*i +: 8] = wd[8*i +: 8];
                        m_bad[wa][i]        = inj;
                    end
                end
            end
            if (r) begin
                e_rdata  = m_mem[ra];
                e_rvalid = 1'b1;
`ifdef DFFMEM_PARITY_EN
                e_perr   = |m_bad[ra];
`endif
            end
        end
        chk("rdata", 32'(rdata), 32'(e_rdata));
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        chk("busy", 32'(busy), 32'(m_busy > 0));
        chk("perr", 32'(perr), 32'(e_perr));
    endtask

    typedef struct {
        logic          w;
        logic [1:0]    b;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          r;
        logic [AW-1:0] ra;
        logic [DW-1:0] x_rdata;
        logic          x_rvalid;
    } vec_t;

    vec_t vecs [7];
    int   busy_cycles;

    initial begin
        // Byte enables, write-first bypass, back-to-back reads, hold when idle.
        vecs[0] = '{1'b1, 2'b11, 3'd7, 16'h1253, 1'b0, 3'd0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 3'd7, 16'hABCD, 1'b0, 3'd0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h12CD, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 3'd3, 16'hBEEF, 1'b1, 3'd3, 16'hBEEF, 1'b1};
        vecs[4] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hBEEF, 1'b1};
        vecs[5] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0000, 1'b1};
        vecs[6] = '{1'b1, 2'b00, 3'd4, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted mid-cycle must clear outputs asynchronously.
        do_cycle(1'b1, 2'b11, 3'd1, 16'h5A5A, 1'b0, 3'd0, 1'b0, 1'b0);
        do_cycle(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, AW'(a), 1'b0, 1'b0);

        // Directed table; the vector expectations are checked on top of the model.
        for (int i = 0; i < 7; i++) begin
            do_cycle(vecs[i].w, vecs[i].b, vecs[i].wa, vecs[i].wd, vecs[i].r, vecs[i].ra, 1'b0, 1'b0);
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].x_rdata));
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].x_rvalid));
        end

        // Clear: fill, clear with a concurrent write, reads while busy are dropped.
        for (int a = 0; a < DEPTH; a++)
            do_cycle(1'b1, 2'b11, AW'(a), 16'h1111 * 16'(a + 1), 1'b0, 3'd0, 1'b0, 1'b0);
        do_cycle(1'b1, 2'b11, 3'd0, 16'hDEAD, 1'b0, 3'd0, 1'b1, 1'b0);
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, AW'(i), 1'b0, 1'b0);
            if (busy) busy_cycles++;
        end
        chk("busy_len", 32'(busy_cycles), 32'd8);
        for (int a = 0; a < DEPTH; a++) begin
            do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, AW'(a), 1'b0, 1'b0);
            chk("clr_word", 32'(rdata), 32'h0);
        end

        // Reset on the 4th busy cycle.
        for (int a = 0; a < DEPTH; a++)
            do_cycle(1'b1, 2'b11, AW'(a), 16'hC3C3 ^ 16'(a), 1'b0, 3'd0, 1'b0, 1'b0);
        do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
        repeat (3) do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("midclr_busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, AW'(a), 1'b0, 1'b0);
            chk("midclr_word", 32'(rdata), 32'h0);
        end

        // Parity injection and repair; perr stays 0 without the parity build.
        do_cycle(1'b1, 2'b11, 3'd2, 16'h00F1, 1'b0, 3'd0, 1'b0, 1'b1);
        do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0);
`ifdef DFFMEM_PARITY_EN
        chk("perr_inj", 32'(perr), 32'h1);
`else
        chk("perr_inj", 32'(perr), 32'h0);
`endif
        do_cycle(1'b1, 2'b11, 3'd2, 16'h00F1, 1'b0, 3'd0, 1'b0, 1'b0);
        do_cycle(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0);
        chk("perr_clean", 32'(perr), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom), 2'($urandom), AW'($urandom), 16'($urandom),
                     1'($urandom), AW'($urandom), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
